// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial pattern detector with overlap control
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   data_in           serial bit, sampled only while data_valid is high
//   cfg_load          one-cycle strobe latching cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern       pattern, bit cfg_len-1 received first, bit 0 last
//   cfg_len           pattern length (clamped to MAX_LEN, 0 never matches)
//   cfg_overlap       1 = overlapping matches, 0 = matched bits are consumed
//   detected          registered one-cycle match pulse
//   match_count       saturating match counter, present only with SEQ_DET_COUNT_EN
module seq_detector_prog #(
   parameter int                 MAX_LEN         = 8,
   parameter int                 LEN_W           = 4,
   parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1010,
   parameter int                 DEFAULT_LEN     = 4,
   parameter int                 COUNT_W         = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               data_in,
   input  logic               data_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               detected
`ifdef SEQ_DET_COUNT_EN
   ,
   output logic [COUNT_W-1:0] match_count
`endif
);
   logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_sh, mask;
   logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_inc, cfg_len_c;
   logic               ovl_q, ovl_d, det_q, det_d, match;
   always_comb begin
      hist_sh   = MAX_LEN'({hist_q, data_in});
      fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
      for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len_q);
      // only the low len_q bits take part, so stale pattern bits above it are ignored
      match     = data_valid && (len_q != '0) && (fill_inc >= len_q) && (((hist_sh ^ pat_q) & mask) == '0);
      cfg_len_c = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      pat_d     = cfg_load ? cfg_pattern : pat_q;
      len_d     = cfg_load ? cfg_len_c : len_q;
      ovl_d     = cfg_load ? cfg_overlap : ovl_q;
      // a sample coinciding with cfg_load is dropped along with the old history
      hist_d    = cfg_load ? '0 : data_valid ? hist_sh : hist_q;
      fill_d    = cfg_load ? '0 : !data_valid ? fill_q : (match && !ovl_q) ? '0 : fill_inc;
      det_d     = !cfg_load && match;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q  <= DEFAULT_PATTERN;
         len_q  <= LEN_W'(DEFAULT_LEN);
         ovl_q  <= 1'b1;
         hist_q <= '0;
         fill_q <= '0;
         det_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         det_q  <= det_d;
      end
   end
   assign detected = det_q;
`ifdef SEQ_DET_COUNT_EN
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = cfg_load ? '0 : (det_d && cnt_q != '1) ? cnt_q + COUNT_W'(1) : cnt_q;
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign match_count = cnt_q;
`endif
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: table vectors, directed corners and random stimulus against a queue-based model
module tb_seq_detector_prog;
   localparam int ML = 8;
   logic       clk, reset, data_in, data_valid, cfg_load, cfg_overlap, detected;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
`ifdef SEQ_DET_COUNT_EN
   logic [1:0] match_count;
`endif
   seq_detector_prog #(.MAX_LEN(8), .LEN_W(4), .DEFAULT_PATTERN(8'b0000_1010), .DEFAULT_LEN(4), .COUNT_W(2)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .detected(detected)
`ifdef SEQ_DET_COUNT_EN
      , .match_count(match_count)
`endif
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      bit         rst, load;
      logic [7:0] pat;
      logic [3:0] len;
      bit         ovl, v, d, e;
   } vec_t;
   vec_t tab[$];
   int   n_vec = 0, n_err = 0;
   bit   mq[$];
   logic [7:0] m_pat;
   int   m_len, m_cnt;
   bit   m_ovl, m_exp;
   function automatic vec_t mk(bit rst, bit load, logic [7:0] pat, logic [3:0] len, bit ovl, bit v, bit d, bit e);
      vec_t t;
      t.rst = rst; t.load = load; t.pat = pat; t.len = len; t.ovl = ovl; t.v = v; t.d = d; t.e = e;
      return t;
   endfunction
   function automatic void add_stream(logic [15:0] bits, int n, logic [15:0] exp);
      for (int i = n - 1; i >= 0; i--) tab.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, bits[i], exp[i]));
   endfunction
   task automatic check(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask
   // reference: keep the bits received since the last clear, match on the newest m_len of them
   task automatic model(vec_t t);
      bit ok;
      m_exp = 0;
      if (t.rst) begin
         m_pat = 8'b0000_1010; m_len = 4; m_ovl = 1; m_cnt = 0; mq.delete();
      end else if (t.load) begin
         m_pat = t.pat; m_len = (t.len > ML) ? ML : int'(t.len); m_ovl = t.ovl; m_cnt = 0; mq.delete();
      end else if (t.v) begin
         mq.push_back(t.d);
         if (mq.size() > ML) void'(mq.pop_front());
         ok = (m_len > 0) && (mq.size() >= m_len);
         for (int i = 0; ok && i < m_len; i++) if (mq[mq.size() - 1 - i] != m_pat[i]) ok = 0;
         if (ok) begin
            m_exp = 1;
            if (m_cnt < 3) m_cnt++;
            if (!m_ovl) mq.delete();
         end
      end
   endtask
   task automatic step(vec_t t, bit chk_tab);
      reset = t.rst; cfg_load = t.load; cfg_pattern = t.pat; cfg_len = t.len;
      cfg_overlap = t.ovl; data_valid = t.v; data_in = t.d;
      model(t);
      @(posedge clk);
      #1;
      check("model_det", int'(detected), int'(m_exp));
      if (chk_tab) check("table_det", int'(detected), int'(t.e));
`ifdef SEQ_DET_COUNT_EN
      check("match_count", int'(match_count), m_cnt);
`endif
   endtask
   initial begin
      vec_t t;
      {reset, cfg_load, cfg_pattern, cfg_len, cfg_overlap, data_valid, data_in} = '0;
      @(posedge clk);
      #1;
      tab.push_back(mk(1, 0, 8'h00, 4'd0, 0, 0, 0, 0));
      add_stream(16'b101010000_10, 11, 16'b000101000_00);
      tab.push_back(mk(0, 1, 8'h0A, 4'd4, 0, 0, 0, 0));
      add_stream(16'b101010000_10, 11, 16'b000100000_00);
      tab.push_back(mk(0, 1, 8'h14, 4'd5, 1, 0, 0, 0));
      add_stream(16'b1010100, 7, 16'b0000001);
      tab.push_back(mk(0, 1, 8'h0A, 4'd4, 1, 0, 0, 0));
      add_stream(16'b101, 3, 16'b000);
      for (int i = 0; i < 3; i++) tab.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 1, 0));
      add_stream(16'b0, 1, 16'b1);
      tab.push_back(mk(0, 1, 8'h0A, 4'd4, 1, 0, 0, 0));
      add_stream(16'b101, 3, 16'b000);
      tab.push_back(mk(1, 1, 8'hFF, 4'd1, 0, 1, 1, 0));
      add_stream(16'b0, 1, 16'b0);
      tab.push_back(mk(0, 1, 8'hFF, 4'd12, 1, 0, 0, 0));
      add_stream(16'hFFF, 12, 16'b0000_0001_1111);
      tab.push_back(mk(0, 1, 8'hFA, 4'd4, 1, 1, 1, 0));
      add_stream(16'b01010, 5, 16'b00001);
      tab.push_back(mk(0, 1, 8'h00, 4'd0, 1, 0, 0, 0));
      add_stream(16'b0000, 4, 16'b0000);
      foreach (tab[i]) step(tab[i], 1);
      // back-to-back overlapping matches, then a valid gap right after a pulse
      step(mk(0, 1, 8'h03, 4'd2, 1, 0, 0, 0), 1);
      step(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0), 1);
      for (int i = 0; i < 4; i++) step(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 1), 1);
      step(mk(0, 0, 8'h00, 4'd0, 0, 0, 1, 0), 1);
      step(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 1), 1);
      // non-overlap with length 2 consumes pairs
      step(mk(0, 1, 8'h03, 4'd2, 0, 0, 0, 0), 1);
      for (int i = 0; i < 6; i++) step(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, bit'(i % 2)), 1);
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 199);
         t = mk(r == 0, r > 0 && r < 6, 8'($urandom), 4'($urandom_range(0, 12)), 1'($urandom),
                $urandom_range(0, 3) != 0, 1'($urandom), 0);
         if (n % 500 == 0) begin
            t.load = 1; t.rst = 0; t.len = 4'($urandom_range(1, 3));
         end
         step(t, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/seq_detector_prog.md
SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (2..32).
REQ-002 Parameter LEN_W, default 4, width of cfg_len; SHALL hold MAX_LEN.
REQ-003 Parameter DEFAULT_PATTERN, default 8'b0000_1010, pattern active after reset.
REQ-004 Parameter DEFAULT_LEN, default 4, pattern length active after reset.
REQ-005 Parameter COUNT_W, default 8, width of match_count.
REQ-006 Port clk  input  1  single clock; all logic rising-edge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port data_in  input  1  serial data bit.
REQ-009 Port data_valid  input  1  data_in is sampled only when high.
REQ-010 Port cfg_load  input  1  one-cycle strobe; latches cfg_pattern, cfg_len, cfg_overlap.
REQ-011 Port cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
REQ-012 Port cfg_len  input  LEN_W  pattern length in bits.
REQ-013 Port cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-014 Port detected  output  1  registered one-cycle match pulse.
REQ-015 Port match_count  output  COUNT_W  saturating match count (present only under SEQ_DET_COUNT_EN).

Function
REQ-016 Block SHALL keep a MAX_LEN-bit history shift register and a fill counter (0..MAX_LEN, saturating).
REQ-017 On each edge with data_valid=1 and cfg_load=0: history shifts left, data_in enters bit 0, fill increments.
REQ-018 A match SHALL occur when fill (after the shift) is >= the active length and the low active-length bits of the new history equal the active pattern's low bits.
REQ-019 detected SHALL be high for exactly the one cycle after the edge that sampled the completing bit; otherwise low.
REQ-020 With data_valid=0: history, fill and counter are held; detected is 0 in the following cycle.
REQ-021 Overlap mode 1: fill is unaffected by a match, so trailing bits may begin the next match.
REQ-022 Overlap mode 0: on a match, fill is cleared to 0 in the same edge, so no matched bit is reused.
REQ-023 cfg_load=1: latch configuration, clear history and fill, force detected to 0 the next cycle; a sample arriving the same cycle SHALL be discarded.
REQ-024 cfg_len > MAX_LEN SHALL be clamped to MAX_LEN; cfg_len=0 SHALL never match.
REQ-025 Pattern bits above the active length SHALL be ignored.
REQ-026 Block SHALL sustain one sample per cycle with no stall condition.

Reset
REQ-027 reset=1 at an edge SHALL clear history, fill, detected and match_count to 0.
REQ-028 Reset SHALL load DEFAULT_PATTERN, DEFAULT_LEN and overlap mode 1.
REQ-029 reset SHALL take priority over cfg_load and data_valid; reset mid-pattern discards partial progress.

Configuration
REQ-030 Macro SEQ_DET_COUNT_EN defined: match_count port exists and increments by 1 per match, saturating at all-ones; it is cleared by reset and by cfg_load.
REQ-031 Macro SEQ_DET_COUNT_EN undefined: match_count port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Defaults (1010, overlap), stream 1,0,1,0,1,0,0,0,0,1,0 -> detected pulses after the 4th and 6th bits only.
REQ-033 Load 1010 with overlap=0, same stream -> single pulse after the 4th bit; count=1.
REQ-034 Load 10100 len 5, stream 1,0,1,0,1,0,0 -> single pulse after the 7th bit.
REQ-035 Load 1010 overlap, send 1,0,1 then hold data_valid=0 for 3 cycles, then 0 -> no pulse during the gap; pulse after the final 0.
REQ-036 Send 1,0,1, assert reset, then 0 -> no pulse; detected=0 and match_count=0 after reset.
REQ-037 Load cfg_len=12 on MAX_LEN=8 with pattern 8'hFF, send 8 ones -> pulse after the 8th bit; with COUNT_W=2, 5 matches -> match_count holds 3.
